// File: rtl/spi_regfile.sv
// ============================================================================
// Module      : spi_regfile
// Description : SPI register-file back end. Assembles address and data bytes
//               from the SPI control strobes, commits writes to shadow
//               registers, serialises read data onto SDO and copies the
//               shadow set to the active outputs on a transfer command.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_regfile #(
    parameter int              NREGS        = 16,
    parameter logic [12:0]     XFER_ADDR    = 13'h0FF,
    parameter bit              ASCEND       = 1'b0,
    parameter logic [NREGS*8-1:0] RESET_VALUES = '0
) (
    input  logic               I_clk,
    input  logic               I_rst,
    input  logic               I_csb_n,
    input  logic               I_sdi,
    input  logic               I_rw,
    input  logic               I_astrobe,
    input  logic               I_dstrobe,
    input  logic               I_sync,
    output logic               O_sdo,
    output logic               O_sdo_oe,
    output logic [NREGS*8-1:0] O_regs,
    output logic               O_xfer
);

    localparam int          IW       = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [12:0] NREGS_A  = 13'(NREGS);
    localparam logic [12:0] ADDR_ONE = 13'd1;

    logic [7:0]  shadow [NREGS];
    logic [7:0]  active [NREGS];
    logic [12:0] addr;
    logic [7:0]  dsh;
    logic [7:0]  rsh;
    logic        sdo_oe;
    logic        xfer;
    logic        xfer_pend;

    logic        addr_hit;
    logic [12:0] addr_next;
    logic [7:0]  wbyte;
    logic [7:0]  rd_byte;

    assign addr_hit  = (addr < NREGS_A);
    assign addr_next = ASCEND ? (addr + ADDR_ONE) : (addr - ADDR_ONE);
    assign wbyte     = {dsh[6:0], I_sdi};

    // Unimplemented addresses, including the transfer register, read as zero.
    always_comb begin
        rd_byte = 8'h00;
        if (addr_hit) begin
            rd_byte = shadow[addr[IW-1:0]];
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            for (int i = 0; i < NREGS; i++) begin
                shadow[i] <= RESET_VALUES[8*i +: 8];
                active[i] <= RESET_VALUES[8*i +: 8];
            end
            addr      <= '0;
            dsh       <= '0;
            rsh       <= '0;
            sdo_oe    <= 1'b0;
            xfer      <= 1'b0;
            xfer_pend <= 1'b0;
        end else begin
            // The copy runs regardless of chip select so a transfer
            // commanded at the end of a frame is never lost.
            xfer      <= xfer_pend;
            xfer_pend <= 1'b0;
            if (xfer_pend) begin
                for (int i = 0; i < NREGS; i++) begin
                    active[i] <= shadow[i];
                end
            end

            if (I_csb_n) begin
                addr   <= '0;
                dsh    <= '0;
                rsh    <= '0;
                sdo_oe <= 1'b0;
            end else begin
                if (I_astrobe) begin
                    addr <= {addr[11:0], I_sdi};
                end
                if (I_dstrobe && !I_rw) begin
                    dsh <= {dsh[6:0], I_sdi};
                end
                if (I_dstrobe && I_rw && !I_sync) begin
                    rsh <= {rsh[6:0], 1'b0};
                end
                if (I_sync) begin
                    addr <= addr_next;
                    if (!I_rw) begin
                        if (addr_hit) begin
                            shadow[addr[IW-1:0]] <= wbyte;
                        end
                        if ((addr == XFER_ADDR) && wbyte[0]) begin
                            xfer_pend <= 1'b1;
                        end
                    end else begin
                        rsh    <= rd_byte;
                        sdo_oe <= 1'b1;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign O_regs[8*g +: 8] = active[g];
    end

    assign O_sdo    = rsh[7];
    assign O_sdo_oe = sdo_oe;
    assign O_xfer   = xfer;

endmodule

`default_nettype wire

// File: tb/tb_spi_regfile.sv
// ============================================================================
// Module      : tb_spi_regfile
// Description : Self-checking bench for spi_regfile with a shadow/active
//               reference model and a queue of expected read bytes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_regfile;

    localparam int           NREGS = 16;
    localparam logic [12:0]  XFER  = 13'h0FF;
    localparam logic [127:0] RV    = 128'h8F8E8D8C8B8A89888786858483828180;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         csb_n = 1'b1;
    logic         sdi = 1'b0;
    logic         rw = 1'b0;
    logic         astrobe = 1'b0;
    logic         dstrobe = 1'b0;
    logic         sync = 1'b0;
    logic         sdo;
    logic         sdo_oe;
    logic [127:0] regs;
    logic         xfer;

    int total = 0;
    int bad = 0;
    int xfer_cnt = 0;

    logic [7:0]   shadow_m [NREGS];
    logic [127:0] active_m;
    logic [12:0]  m_addr;
    logic [7:0]   exp_q [$];

    spi_regfile #(
        .NREGS(NREGS),
        .XFER_ADDR(XFER),
        .ASCEND(1'b0),
        .RESET_VALUES(RV)
    ) dut (
        .I_clk(clk),
        .I_rst(rst),
        .I_csb_n(csb_n),
        .I_sdi(sdi),
        .I_rw(rw),
        .I_astrobe(astrobe),
        .I_dstrobe(dstrobe),
        .I_sync(sync),
        .O_sdo(sdo),
        .O_sdo_oe(sdo_oe),
        .O_regs(regs),
        .O_xfer(xfer)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (xfer === 1'b1) xfer_cnt++;
    end

    always @(posedge clk) begin
        if (!csb_n) begin
            assert (!(astrobe && dstrobe)) else $error("illegal strobe combination: astrobe and dstrobe both high");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic cyc(input logic c, input logic a, input logic d, input logic s, input logic b);
        csb_n = c; astrobe = a; dstrobe = d; sync = s; sdi = b;
        @(posedge clk); #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) shadow_m[i] = RV[8*i +: 8];
        active_m = RV;
    endtask

    function automatic logic [127:0] shadow_flat();
        logic [127:0] f;
        for (int i = 0; i < NREGS; i++) f[8*i +: 8] = shadow_m[i];
        return f;
    endfunction

    task automatic frame_start(input logic r, input logic [12:0] a, input int abits);
        rw = r;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = abits - 1; i >= 0; i--) cyc(1'b0, 1'b1, 1'b0, 1'b0, a[i]);
        m_addr = a;
    endtask

    task automatic end_frame();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic write_byte(input logic [7:0] b, input int nbits);
        for (int i = nbits - 1; i >= 1; i--) cyc(1'b0, 1'b0, 1'b1, 1'b0, b[i]);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, b[0]);
        if (m_addr < 13'(NREGS)) shadow_m[m_addr[3:0]] = b;
        m_addr = m_addr - 13'd1;
    endtask

    task automatic read_byte();
        logic [7:0] got;
        logic [7:0] exp;
        logic       oe_ok;
        exp_q.push_back((m_addr < 13'(NREGS)) ? shadow_m[m_addr[3:0]] : 8'h00);
        m_addr = m_addr - 13'd1;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        got[7] = sdo;
        oe_ok  = (sdo_oe === 1'b1);
        for (int k = 6; k >= 0; k--) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            got[k] = sdo;
            oe_ok  = oe_ok && (sdo_oe === 1'b1);
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        exp = exp_q.pop_front();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL read_data: got %h expected %h", got, exp);
        end
        total++;
        if (!oe_ok) begin
            bad++;
            $display("FAIL read_oe: sdo_oe not held at 1 during data, expected 1");
        end
    endtask

    task automatic read_frame(input logic [12:0] a, input int abits, input int n);
        frame_start(1'b1, a, abits);
        for (int i = 0; i < n; i++) read_byte();
        end_frame();
    endtask

    task automatic check_regs(input string name);
        total++;
        if (regs !== active_m) begin
            bad++;
            $display("FAIL %s: O_regs=%h expected %h", name, regs, active_m);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        total++;
        if ({sdo, sdo_oe, xfer} !== 3'b000) begin
            bad++;
            $display("FAIL reset_outputs: sdo/oe/xfer=%b expected 000", {sdo, sdo_oe, xfer});
        end
        check_regs("reset_regs");
        rst = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_write_read();
        frame_start(1'b0, 13'h005, 13);
        write_byte(8'hA5, 8);
        end_frame();
        total++;
        if (sdo_oe !== 1'b0) begin
            bad++;
            $display("FAIL write_oe: sdo_oe=%b expected 0", sdo_oe);
        end
        read_frame(13'h005, 13, 1);
        total++;
        if (regs[47:40] !== 8'h85) begin
            bad++;
            $display("FAIL active_untouched: byte5=%h expected 85", regs[47:40]);
        end
    endtask

    task automatic test_xfer();
        frame_start(1'b0, XFER, 13);
        write_byte(8'h01, 8);
        total++;
        if (xfer !== 1'b0) begin
            bad++;
            $display("FAIL xfer_early: O_xfer=%b expected 0", xfer);
        end
        check_regs("xfer_early_regs");
        end_frame();
        active_m = shadow_flat();
        total++;
        if (xfer !== 1'b1) begin
            bad++;
            $display("FAIL xfer_pulse: O_xfer=%b expected 1", xfer);
        end
        total++;
        if (regs[47:40] !== 8'hA5) begin
            bad++;
            $display("FAIL xfer_byte5: byte5=%h expected a5", regs[47:40]);
        end
        check_regs("xfer_regs");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (xfer !== 1'b0) begin
            bad++;
            $display("FAIL xfer_width: O_xfer=%b expected 0", xfer);
        end
        read_frame(XFER, 13, 1);
    endtask

    task automatic test_stream();
        frame_start(1'b0, 13'h001, 13);
        write_byte(8'h11, 8);
        write_byte(8'h22, 8);
        write_byte(8'h33, 8);
        end_frame();
        check_regs("stream_regs");
        read_frame(13'h00F, 13, NREGS);
        read_frame(13'h000, 13, 2);
    endtask

    task automatic test_unimpl();
        read_frame(13'h020, 13, 1);
        check_regs("unimpl_regs");
    endtask

    task automatic test_abort();
        frame_start(1'b0, 13'h003, 13);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        end_frame();
        read_frame(13'h003, 5, 2);
        frame_start(1'b0, 13'h002, 13);
        write_byte(8'h0A, 4);
        end_frame();
        read_frame(13'h002, 13, 1);
        check_regs("abort_regs");
    endtask

    task automatic test_reset_mid();
        frame_start(1'b1, 13'h005, 13);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        total++;
        if ({sdo, sdo_oe} !== 2'b11) begin
            bad++;
            $display("FAIL midread_start: sdo/oe=%b expected 11", {sdo, sdo_oe});
        end
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        model_reset();
        total++;
        if ({sdo, sdo_oe, xfer} !== 3'b000) begin
            bad++;
            $display("FAIL midread_reset: sdo/oe/xfer=%b expected 000", {sdo, sdo_oe, xfer});
        end
        check_regs("midread_regs");
        rst = 1'b0;
        end_frame();
        read_frame(13'h005, 13, 1);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_xfer();
        test_stream();
        test_unimpl();
        test_abort();
        test_reset_mid();
        total++;
        if (xfer_cnt !== 1) begin
            bad++;
            $display("FAIL xfer_count: pulses=%0d expected 1", xfer_cnt);
        end
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_regfile.md
Name: spi_regfile

Overview:
Register-file back end for the ADC SPI port. It consumes the rw/astrobe/dstrobe/sync strobes from the SPI control FSM together with the raw serial data. It assembles the 13-bit address and 8-bit data bytes, commits writes to shadow registers, and serialises read data onto SDO. Writes to a transfer register copy the shadow set to the active register outputs that drive ADC configuration.

Parameters:
NREGS, 16, number of implemented 8-bit registers at addresses 0..NREGS-1 (NREGS <= 255)
XFER_ADDR, 13'h0FF, address of the self-clearing transfer register
ASCEND, 0, streaming address direction (0 = decrement after each byte, 1 = increment)
RESET_VALUES, {NREGS*8{1'b0}}, reset contents of shadow and active registers; byte i is bits [8i+7:8i]

Ports:
I_clk  in  1  serial clock (SCLK domain), rising-edge
I_rst  in  1  synchronous active-high reset
I_csb_n  in  1  chip select, active low, sampled on I_clk
I_sdi  in  1  serial data in
I_rw  in  1  1 = read frame, 0 = write frame (from SPI control)
I_astrobe  in  1  address-bit strobe
I_dstrobe  in  1  data-bit strobe
I_sync  in  1  byte boundary pulse
O_sdo  out  1  serial read data, MSB first
O_sdo_oe  out  1  SDO drive enable
O_regs  out  NREGS*8  active register contents, flat
O_xfer  out  1  one-cycle pulse when the active registers update

Behaviour:
- Reset (I_rst=1, highest priority): shadow and active registers = RESET_VALUES; address shifter, data shifter and read shifter = 0; O_sdo=0, O_sdo_oe=0, O_xfer=0.
- Frame idle (I_csb_n=1, no reset): clear address, data and read shifters; O_sdo_oe=0. Register contents are preserved. Strobes are ignored.
- All of the following apply only when I_csb_n=0.
- Address: each cycle with I_astrobe=1, addr <= {addr[11:0], I_sdi}. Exactly 13 strobes per frame give the full address, MSB first.
- Write data: each cycle with I_dstrobe=1 and I_rw=0, dsh <= {dsh[6:0], I_sdi}. This includes the sync cycle.
- Write commit: on a cycle with I_sync=1 and I_rw=0, the byte is wbyte={dsh[6:0], I_sdi}.
  - If addr<NREGS: shadow[addr] <= wbyte.
  - If addr==XFER_ADDR and wbyte[0]=1: set xfer_pend.
  - Any other address: write ignored, no error.
  - In the same cycle, addr <= addr-1 (ASCEND=0) or addr+1 (ASCEND=1), modulo 2^13. 13'h0000-1 wraps to 13'h1FFF; 13'h1FFF+1 wraps to 13'h0000.
- Transfer: the cycle after xfer_pend is set, all active registers <= shadow, O_xfer=1 for exactly one cycle, and xfer_pend clears.
  - A transfer started before csb rises still completes on the next I_clk edge, even if I_csb_n=1.
  - Reading XFER_ADDR returns 0x00 (self-clearing).
  - If a write to shadow[k] commits in the same cycle as the transfer copy, active[k] receives the old shadow value; the new value becomes active on the next transfer.
- Read load: on a cycle with I_sync=1 and I_rw=1:
  - rsh <= shadow[addr] if addr<NREGS, else 0x00;
  - O_sdo_oe <= 1;
  - addr steps by ±1 as for writes.
- Read shift: each cycle with I_dstrobe=1, I_rw=1 and I_sync=0, rsh <= {rsh[6:0],1'b0}.
- O_sdo = rsh[7] (registered). The first data bit appears the cycle after sync; 8 bits then follow on successive dstrobe cycles.
- O_sdo_oe stays 1 until I_csb_n=1 or I_rst. It is never asserted in write frames.
- Reads return shadow values. O_regs always reflects the active registers.
- Latency:
  - write sync edge to shadow update: 1 edge;
  - commit to XFER_ADDR to O_regs update: 2 edges;
  - read sync to first bit on O_sdo: 1 edge.
- Reset mid-frame: all state cleared as above. A following frame requires the control FSM to restart, i.e. I_csb_n toggles.
- Strobe combinations outside the control FSM's legal sequences (astrobe and dstrobe both high) are undefined. A bench assertion must flag them.

Test Plan:
- Write 0xA5 to addr 0x005, then read addr 0x005 -> read returns 0xA5 MSB-first on O_sdo (1,0,1,0,0,1,0,1), O_sdo_oe=1 during data; O_regs byte 5 still equals RESET_VALUES byte 5.
- Write 0x01 to XFER_ADDR after the above -> O_xfer pulses once 2 edges after sync; O_regs[47:40]=0xA5; a subsequent read of 0x0FF returns 0x00.
- Streaming write, ASCEND=0, start addr 0x001, bytes 0x11,0x22,0x33 -> shadow[1]=0x11, shadow[0]=0x22; the third byte lands at 0x1FFF and is ignored; nothing else changes.
- Read addr 0x020 (unimplemented) -> O_sdo stays 0 for 8 bits; no register changes.
- I_csb_n rises after 4 data bits of a write to addr 0x003 -> shadow[3] unchanged; next frame's address assembles from a zero shifter.
- Assert I_rst mid-read with O_sdo_oe=1 -> next edge O_sdo=0, O_sdo_oe=0, O_regs=RESET_VALUES, O_xfer=0.
